// File: rtl/dom_ssaes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dom_ssaes_pkg
// Summary  : Shared types, LFSR constants and sizing helpers for the DOM
//            small-scale AES randomness feeder.
// Revision : 1.0 - initial release
// ============================================================================
package dom_ssaes_pkg;

    // Width of the mask-generation LFSR state
    localparam int c_LFSR_W = 128;

    // Low-order feedback terms of x^128 + x^7 + x^2 + x + 1 (bits 7, 2, 1, 0)
    localparam logic [c_LFSR_W-1:0] c_LFSR_TAPS = 128'h87;

    // Feeder control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Integer ceiling division used to size the fill sequences
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dom_ssaes_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : dom_ssaes_lfsr
// Summary  : 128-bit Galois LFSR unrolled GEN_W steps per advance. The bits
//            shifted out of the MSB form o_gen, first bit out at o_gen MSB.
// Revision : 1.0 - initial release
// ============================================================================
module dom_ssaes_lfsr
    import dom_ssaes_pkg::*;
#(
    parameter int GEN_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [c_LFSR_W-1:0] i_seed,
    input  logic                i_advance,
    output logic [GEN_W-1:0]    o_gen
);

    logic [c_LFSR_W-1:0] r_state;
    logic [c_LFSR_W-1:0] w_next;
    logic [GEN_W-1:0]    w_gen;

    // Unroll GEN_W left-shift Galois steps, collecting each shifted-out bit
    always_comb begin
        logic [c_LFSR_W-1:0] v_s;
        v_s   = r_state;
        w_gen = '0;
        for (int i = 0; i < GEN_W; i++) begin
            w_gen[GEN_W-1-i] = v_s[c_LFSR_W-1];
            v_s = {v_s[c_LFSR_W-2:0], 1'b0} ^ (v_s[c_LFSR_W-1] ? c_LFSR_TAPS : '0);
        end
        w_next = v_s;
    end

    // State register: seed load has priority over advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_advance) begin
            r_state <= w_next;
        end
    end

    assign o_gen = w_gen;

endmodule
`default_nettype wire

// File: rtl/dom_ssaes_rand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dom_ssaes_rand_feeder
// Summary  : Expands a host seed into text/key masks and one fresh
//            random_bits word per round period for a DOM masked AES core.
// Revision : 1.0 - initial release
// ============================================================================
module dom_ssaes_rand_feeder
    import dom_ssaes_pkg::*;
#(
    parameter int STATE_W       = 64,
    parameter int RAND_W        = 360,
    parameter int GEN_W         = 128,
    parameter int ROUNDS        = 10,
    parameter int CYC_PER_ROUND = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seed_valid,
    input  logic [c_LFSR_W-1:0] seed_in,
    input  logic                start,
    input  logic                abort,
    output logic                core_start,
    output logic [STATE_W-1:0]  t_mask,
    output logic [STATE_W-1:0]  k_mask,
    output logic [RAND_W-1:0]   random_bits,
    output logic                busy,
    output logic                done,
    output logic                seed_err
);

    localparam int c_FILL   = ceil_div(RAND_W, GEN_W);
    localparam int c_MFILL  = ceil_div(2 * STATE_W, GEN_W);
    localparam int c_P      = c_MFILL + c_FILL;
    localparam int c_MACC_W = c_MFILL * GEN_W;
    localparam int c_PRE_W  = $clog2(c_P);
    localparam int c_PER_W  = (CYC_PER_ROUND > 1) ? $clog2(CYC_PER_ROUND) : 1;
    localparam int c_RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_LAST      = c_PRE_W'(c_P - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_MASK_LAST = c_PRE_W'(c_MFILL - 1);
    localparam logic [c_PER_W-1:0] c_PER_LAST      = c_PER_W'(CYC_PER_ROUND - 1);
    localparam logic [c_PER_W-1:0] c_PER_FILL_LAST = c_PER_W'(c_FILL - 1);
    localparam logic [c_RND_W-1:0] c_RND_LAST      = c_RND_W'(ROUNDS - 1);

    // A period shorter than the refill sequence cannot deliver fresh words
    generate
        if (CYC_PER_ROUND < c_FILL) begin : g_cfg_err
            $error("dom_ssaes_rand_feeder: CYC_PER_ROUND must be >= FILL");
        end
    endgenerate

    state_t               r_state;
    logic                 r_seeded;
    logic [c_PRE_W-1:0]   r_pre_cnt;
    logic [c_PER_W-1:0]   r_per_cnt;
    logic [c_RND_W-1:0]   r_rnd_cnt;
    logic [c_MACC_W-1:0]  r_mask_acc;
    logic [RAND_W-1:0]    r_fill;
    logic [STATE_W-1:0]   r_t_mask;
    logic [STATE_W-1:0]   r_k_mask;
    logic [RAND_W-1:0]    r_random_bits;
    logic                 r_core_start;
    logic                 r_seed_err;

    logic                 w_idle;
    logic                 w_pre;
    logic                 w_run;
    logic                 w_pre_mask;
    logic                 w_pre_fill;
    logic                 w_run_fill;
    logic                 w_adv_mask;
    logic                 w_adv_fill;
    logic                 w_seed_ok;
    logic                 w_load;
    logic                 w_pre_last;
    logic                 w_per_last;
    logic                 w_rnd_last;
    logic                 w_err;
    logic [GEN_W-1:0]     w_gen;
    logic [c_MACC_W-1:0]  w_mask_next;
    logic [RAND_W-1:0]    w_fill_next;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_pre      = (r_state == ST_PRE);
    assign w_run      = (r_state == ST_RUN);
    assign w_pre_mask = w_pre && (r_pre_cnt <= c_PRE_MASK_LAST);
    assign w_pre_fill = w_pre && (r_pre_cnt > c_PRE_MASK_LAST);
    assign w_run_fill = w_run && (r_per_cnt <= c_PER_FILL_LAST);
    // An aborting cycle leaves the LFSR untouched so the next run continues it
    assign w_adv_mask = w_pre_mask && !abort;
    assign w_adv_fill = (w_pre_fill || w_run_fill) && !abort;
    assign w_seed_ok  = (seed_in != '0);
    assign w_load     = w_idle && seed_valid && w_seed_ok;
    assign w_pre_last = w_pre && (r_pre_cnt == c_PRE_LAST);
    assign w_per_last = w_run && (r_per_cnt == c_PER_LAST);
    assign w_rnd_last = (r_rnd_cnt == c_RND_LAST);

    // Zero seed, unseeded start, or any seed attempt while busy
    assign w_err = (w_idle && seed_valid && !w_seed_ok)
                || (w_idle && start && !seed_valid && !r_seeded)
                || (!w_idle && seed_valid);

    // Shift accumulators: newest word enters at the LSB end, oldest bits fall off the top
    assign w_mask_next = c_MACC_W'({r_mask_acc, w_gen});
    assign w_fill_next = w_adv_fill ? RAND_W'({r_fill, w_gen}) : r_fill;

    dom_ssaes_lfsr #(
        .GEN_W     (GEN_W)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_seed    (seed_in),
        .i_advance (w_adv_mask || w_adv_fill),
        .o_gen     (w_gen)
    );

    // Control FSM, seeded flag and period/round counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_seeded     <= 1'b0;
            r_pre_cnt    <= '0;
            r_per_cnt    <= '0;
            r_rnd_cnt    <= '0;
            r_core_start <= 1'b0;
            r_seed_err   <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            r_seed_err   <= w_err;
            case (r_state)
                ST_IDLE: begin
                    if (seed_valid) begin
                        if (w_seed_ok) begin
                            r_seeded <= 1'b1;
                        end
                    end else if (start && r_seeded) begin
                        r_state   <= ST_PRE;
                        r_pre_cnt <= '0;
                    end
                end
                ST_PRE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_pre_last) begin
                        r_state      <= ST_RUN;
                        r_per_cnt    <= '0;
                        r_rnd_cnt    <= '0;
                        r_core_start <= 1'b1;
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_per_last) begin
                        r_per_cnt <= '0;
                        if (w_rnd_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_rnd_cnt <= r_rnd_cnt + 1'b1;
                        end
                    end else begin
                        r_per_cnt <= r_per_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Mask/fill accumulators and the registered mask and randomness outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mask_acc    <= '0;
            r_fill        <= '0;
            r_t_mask      <= '0;
            r_k_mask      <= '0;
            r_random_bits <= '0;
        end else begin
            if (w_adv_mask) begin
                r_mask_acc <= w_mask_next;
            end
            r_fill <= w_fill_next;
            if (!w_idle && abort) begin
                r_t_mask      <= '0;
                r_k_mask      <= '0;
                r_random_bits <= '0;
            end else if (w_pre_last) begin
                {r_t_mask, r_k_mask} <= r_mask_acc[c_MACC_W-1 -: 2*STATE_W];
                r_random_bits        <= w_fill_next;
            end else if (w_per_last && !w_rnd_last) begin
                r_random_bits <= w_fill_next;
            end
        end
    end

    assign core_start  = r_core_start;
    assign t_mask      = r_t_mask;
    assign k_mask      = r_k_mask;
    assign random_bits = r_random_bits;
    assign busy        = !w_idle;
    assign done        = w_per_last && w_rnd_last && !abort;
    assign seed_err    = r_seed_err;

endmodule
`default_nettype wire
